// File: rtl/dpram_read_streamer_pkg.sv
// Shared types for the DPRAM read streamer: controller state encoding and
// the width rule for the word-count input.
package dpram_read_streamer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_FETCH = 2'b01,
      ST_DRAIN = 2'b10
   } state_t;

   // LEN must represent 0..2^addr_width inclusive, hence one extra bit.
   function automatic int len_width(input int addr_width);
      return addr_width + 1;
   endfunction

endpackage

// File: rtl/dpram_rd_skid.sv
// Two-entry output buffer for the read streamer; head register drives the
// stream outputs directly so they stay stable while the consumer stalls.
module dpram_rd_skid
   import dpram_read_streamer_pkg::*;
#(
   parameter int dataWidth = 16
)
(
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 push,
   input  logic [dataWidth-1:0] push_data,
   input  logic                 push_last,
   input  logic                 pop,
   output logic [dataWidth-1:0] head_data,
   output logic                 head_last,
   output logic                 full,
   output logic                 empty
);

   logic [1:0]           count_r;
   logic [dataWidth-1:0] head_data_r;
   logic                 head_last_r;
   logic [dataWidth-1:0] tail_data_r;
   logic                 tail_last_r;

   // Occupancy and entry storage; simultaneous push/pop keeps the count.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         count_r     <= 2'd0;
         head_data_r <= {dataWidth{1'b0}};
         head_last_r <= 1'b0;
         tail_data_r <= {dataWidth{1'b0}};
         tail_last_r <= 1'b0;
      end else begin
         case (count_r)
            2'd0: begin
               if (push) begin
                  head_data_r <= push_data;
                  head_last_r <= push_last;
                  count_r     <= 2'd1;
               end
            end
            2'd1: begin
               if (push && pop) begin
                  head_data_r <= push_data;
                  head_last_r <= push_last;
               end else if (push) begin
                  tail_data_r <= push_data;
                  tail_last_r <= push_last;
                  count_r     <= 2'd2;
               end else if (pop) begin
                  count_r     <= 2'd0;
               end
            end
            2'd2: begin
               if (pop) begin
                  head_data_r <= tail_data_r;
                  head_last_r <= tail_last_r;
                  if (push) begin
                     tail_data_r <= push_data;
                     tail_last_r <= push_last;
                  end else begin
                     count_r <= 2'd1;
                  end
               end
            end
            default: count_r <= 2'd0;
         endcase
      end
   end

   assign head_data = head_data_r;
   assign head_last = head_last_r;
   assign full      = (count_r == 2'd2);
   assign empty     = (count_r == 2'd0);

endmodule

// File: rtl/dpram_read_streamer.sv
// Streams a contiguous (wrapping) region of an asynchronous-read RAM out
// through a valid/ready interface, one word per cycle when unstalled.
module dpram_read_streamer
   import dpram_read_streamer_pkg::*;
#(
   parameter int addrWidth = 5,
   parameter int dataWidth = 16
)
(
   input  logic                              CLK,
   input  logic                              RST,
   input  logic                              START,
   input  logic [addrWidth-1:0]              BASE,
   input  logic [len_width(addrWidth)-1:0]   LEN,
   output logic [addrWidth-1:0]              RADDR,
   input  logic [dataWidth-1:0]              RDATA,
   output logic                              OUT_VALID,
   input  logic                              OUT_READY,
   output logic [dataWidth-1:0]              OUT_DATA,
   output logic                              OUT_LAST,
   output logic                              BUSY,
   output logic                              DONE
);

   localparam int LenW = len_width(addrWidth);

   state_t              state_r;
   state_t              state_nxt_s;
   logic [addrWidth-1:0] raddr_r;
   logic [LenW-1:0]      rem_r;
   logic                 busy_r;
   logic                 done_r;
   logic                 start_acc_s;
   logic                 len_zero_s;
   logic                 push_s;
   logic                 pop_s;
   logic                 last_push_s;
   logic                 last_pop_s;
   logic                 full_s;
   logic                 empty_s;
   logic                 head_last_s;
   logic [dataWidth-1:0] head_data_s;

   // Handshake qualifiers: capture whenever the buffer has (or is making) room.
   always_comb begin
      start_acc_s = (state_r == ST_IDLE) && START;
      len_zero_s  = (LEN == {LenW{1'b0}});
      pop_s       = OUT_READY && !empty_s;
      push_s      = (state_r == ST_FETCH) && (!full_s || pop_s);
      last_push_s = push_s && (rem_r == LenW'(1));
      last_pop_s  = pop_s && head_last_s;
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (START && !len_zero_s) state_nxt_s = ST_FETCH;
            else                      state_nxt_s = ST_IDLE;
         end
         ST_FETCH: begin
            if (last_push_s) state_nxt_s = ST_DRAIN;
            else             state_nxt_s = ST_FETCH;
         end
         ST_DRAIN: begin
            if (last_pop_s) state_nxt_s = ST_IDLE;
            else            state_nxt_s = ST_DRAIN;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State, address/count registers and status flags.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r <= ST_IDLE;
         raddr_r <= {addrWidth{1'b0}};
         rem_r   <= {LenW{1'b0}};
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         busy_r  <= (state_nxt_s != ST_IDLE);
         // A zero-length request completes without ever leaving IDLE.
         done_r  <= (start_acc_s && len_zero_s) ||
                    ((state_r == ST_DRAIN) && last_pop_s);
         if (start_acc_s) begin
            raddr_r <= BASE;
            rem_r   <= LEN;
         end else if (push_s) begin
            raddr_r <= raddr_r + addrWidth'(1);
            rem_r   <= rem_r - LenW'(1);
         end
      end
   end

   dpram_rd_skid #(
      .dataWidth (dataWidth)
   ) u_skid (
      .CLK       (CLK),
      .RST       (RST),
      .push      (push_s),
      .push_data (RDATA),
      .push_last (last_push_s),
      .pop       (pop_s),
      .head_data (head_data_s),
      .head_last (head_last_s),
      .full      (full_s),
      .empty     (empty_s)
   );

   assign RADDR     = raddr_r;
   assign OUT_VALID = !empty_s;
   assign OUT_DATA  = head_data_s;
   assign OUT_LAST  = head_last_s;
   assign BUSY      = busy_r;
   assign DONE      = done_r;

endmodule

// File: tb/tb_dpram_read_streamer.sv
// Scoreboard bench: each transfer pushes the words a RAM walk should yield;
// an independent monitor pops and compares on every output handshake.
module tb_dpram_read_streamer;

   logic        CLK;
   logic        RST;
   logic        START;
   logic [4:0]  BASE;
   logic [5:0]  LEN;
   logic [4:0]  RADDR;
   logic [15:0] RDATA;
   logic        OUT_VALID;
   logic        OUT_READY;
   logic [15:0] OUT_DATA;
   logic        OUT_LAST;
   logic        BUSY;
   logic        DONE;

   logic [15:0] mem [0:31];
   logic [16:0] exp_q [$];
   int          vectors = 0;
   int          errors  = 0;
   int          hs      = 0;
   int          rmode   = 0;

   dpram_read_streamer #(.addrWidth(5), .dataWidth(16)) dut (
      .CLK(CLK), .RST(RST), .START(START), .BASE(BASE), .LEN(LEN),
      .RADDR(RADDR), .RDATA(RDATA), .OUT_VALID(OUT_VALID),
      .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA), .OUT_LAST(OUT_LAST),
      .BUSY(BUSY), .DONE(DONE)
   );

   assign RDATA = mem[RADDR];

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Consumer ready pattern: 0 = always ready, 1 = random, 2 = 1,0,0 repeating.
   initial begin
      int ph = 0;
      OUT_READY = 1'b1;
      forever begin
         @(negedge CLK);
         case (rmode)
            0:       OUT_READY = 1'b1;
            1:       OUT_READY = 1'($urandom_range(0, 1));
            default: OUT_READY = (ph % 3 == 0);
         endcase
         ph++;
      end
   end

   // Monitor: handshake occurs at the next rising edge when valid && ready.
   initial begin
      logic        prev_stall = 1'b0;
      logic [15:0] prev_data  = 16'd0;
      logic [16:0] e;
      forever begin
         @(negedge CLK);
         #2;
         if (RST) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("stall_hold_data", 32'(OUT_DATA), 32'(prev_data));
               chk("stall_hold_valid", 32'(OUT_VALID), 32'd1);
            end
            if (OUT_VALID && OUT_READY) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_word", 32'(OUT_DATA), 32'hFFFF_FFFF);
               end else begin
                  e = exp_q.pop_front();
                  chk("out_data", 32'(OUT_DATA), 32'(e[15:0]));
                  chk("out_last", 32'(OUT_LAST), 32'(e[16]));
                  hs++;
               end
            end
            prev_stall = OUT_VALID && !OUT_READY;
            prev_data  = OUT_DATA;
         end
      end
   end

   // Reference: word k of a transfer comes from (base+k) mod 32; last on k=len-1.
   task automatic expect_words(input int base, input int len);
      for (int k = 0; k < len; k++) begin
         logic [16:0] w;
         w[15:0] = mem[(base + k) % 32];
         w[16]   = (k == len - 1);
         exp_q.push_back(w);
      end
   endtask

   // Called at a falling edge; returns at a falling edge with the DUT idle.
   task automatic run_xfer(input int base, input int len, input bit timed, input bit inject);
      int n;
      chk("idle_before_start", 32'(BUSY), 32'd0);
      START = 1'b1;
      BASE  = 5'(base);
      LEN   = 6'(len);
      expect_words(base, len);
      @(negedge CLK);
      START = 1'b0;
      n = 1;
      chk("busy_after_start", 32'(BUSY), (len != 0) ? 32'd1 : 32'd0);
      if (timed) chk("no_valid_t1", 32'(OUT_VALID), 32'd0);
      while (!DONE && n < 400) begin
         @(negedge CLK);
         n++;
         if (timed && n == 2) chk("first_valid_t2", 32'(OUT_VALID), 32'd1);
         if (inject && n == 2) begin
            chk("busy_at_inject", 32'(BUSY), 32'd1);
            START = 1'b1;
            BASE  = 5'd20;
            LEN   = 6'd6;
         end
         if (inject && n == 3) START = 1'b0;
      end
      chk("done_seen", 32'(DONE), 32'd1);
      if (timed) chk("done_cycle", 32'(n), (len == 0) ? 32'd1 : 32'(len + 2));
      chk("busy_at_done", 32'(BUSY), 32'd0);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      @(negedge CLK);
      chk("done_one_cycle", 32'(DONE), 32'd0);
      chk("idle_no_valid", 32'(OUT_VALID), 32'd0);
   endtask

   initial begin
      int k;
      int hs0;
      RST   = 1'b1;
      START = 1'b0;
      BASE  = 5'd0;
      LEN   = 6'd0;
      for (int i = 0; i < 32; i++) mem[i] = 16'(i);
      repeat (2) @(negedge CLK);
      chk("rst_valid", 32'(OUT_VALID), 32'd0);
      chk("rst_raddr", 32'(RADDR), 32'd0);
      chk("rst_data", 32'(OUT_DATA), 32'd0);
      chk("rst_last", 32'(OUT_LAST), 32'd0);
      chk("rst_busy", 32'(BUSY), 32'd0);
      chk("rst_done", 32'(DONE), 32'd0);
      RST = 1'b0;

      run_xfer(3, 4, 1'b1, 1'b0);
      run_xfer(30, 4, 1'b1, 1'b0);
      rmode = 2;
      run_xfer(10, 5, 1'b0, 1'b0);
      rmode = 0;
      run_xfer(9, 0, 1'b1, 1'b0);
      run_xfer(5, 3, 1'b1, 1'b1);

      // Abort a transfer after two words have been consumed.
      START = 1'b1;
      BASE  = 5'd0;
      LEN   = 6'd8;
      expect_words(0, 8);
      hs0 = hs;
      @(negedge CLK);
      START = 1'b0;
      k = 0;
      while (hs < hs0 + 2 && k < 50) begin
         @(negedge CLK);
         k++;
      end
      chk("two_words_before_abort", 32'(hs - hs0), 32'd2);
      #1;
      RST = 1'b1;
      exp_q.delete();
      #1;
      chk("abort_valid", 32'(OUT_VALID), 32'd0);
      chk("abort_busy", 32'(BUSY), 32'd0);
      chk("abort_done", 32'(DONE), 32'd0);
      chk("abort_raddr", 32'(RADDR), 32'd0);
      chk("abort_data", 32'(OUT_DATA), 32'd0);
      @(negedge CLK);
      chk("abort_no_done", 32'(DONE), 32'd0);
      RST = 1'b0;
      run_xfer(0, 1, 1'b1, 1'b0);

      run_xfer(7, 32, 1'b1, 1'b0);

      for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
      for (int i = 0; i < 20; i++) begin
         int b;
         int l;
         rmode = int'($urandom_range(0, 2));
         b = int'($urandom_range(0, 31));
         l = ($urandom_range(0, 5) == 0) ? 32 : int'($urandom_range(0, 32));
         run_xfer(b, l, rmode == 0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
